// File: rtl/dsram_req_ctrl_pkg.sv
// Shared encodings for the data-SRAM request controller: access sizes,
// controller states and the registered request bundle.
package dsram_req_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DSRAM_REQ_WD = 71;

  typedef enum logic {
    DRC_IDLE = 1'b0,
    DRC_REQ  = 1'b1
  } drc_state_e;

  // Field order gives wr + size + addr + wstrb + wdata = DSRAM_REQ_WD bits.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dsram_req_t;

endpackage

// File: rtl/dsram_req_ctrl_resp_fifo.sv
// Circular buffer holding returned SRAM data until MEM takes it.
// A clear drops every entry and overrides a same-cycle push or pop.
module dsram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & !o_empty;
  assign w_do_push = i_push & (!o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear && !i_reset) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM request controller between EX and MEM: holds one request until
// addr_ok, tracks outstanding accesses and buffers responses for MEM.
//
// state    | meaning
// DRC_IDLE | no request held; may accept a new access from EX
// DRC_REQ  | request registered and driven on the port until addr_ok/flush
module dsram_req_ctrl
  import dsram_req_ctrl_pkg::*;
#(
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_es_req_valid,
  input  logic        i_es_req_wr,
  input  logic [1:0]  i_es_req_size,
  input  logic [31:0] i_es_req_addr,
  input  logic [3:0]  i_es_req_wstrb,
  input  logic [31:0] i_es_req_wdata,
  output logic        o_es_req_ready,
  input  logic        i_flush,
  output logic        o_data_sram_req,
  output logic        o_data_sram_wr,
  output logic [1:0]  o_data_sram_size,
  output logic [31:0] o_data_sram_addr,
  output logic [3:0]  o_data_sram_wstrb,
  output logic [31:0] o_data_sram_wdata,
  input  logic        i_data_sram_addr_ok,
  input  logic        i_data_sram_data_ok,
  input  logic [31:0] i_data_sram_rdata,
  output logic        o_ms_resp_valid,
  output logic [31:0] o_ms_resp_rdata,
  input  logic        i_ms_resp_ready,
  output logic        o_busy
);

  drc_state_e       r_state;
  drc_state_e       w_state_nxt;
  dsram_req_t       r_req;
  logic [CNT_W-1:0] r_live_cnt;
  logic [CNT_W-1:0] r_cancel_cnt;
  logic [CNT_W-1:0] w_fifo_cnt;
  logic [CNT_W:0]   w_pending;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_accept;
  logic             w_addr_acc;
  logic             w_data_ok_live;
  logic             w_data_ok_cancel;
  logic             w_push;
  logic             w_pop;

  assign w_pending        = {1'b0, r_live_cnt} + {1'b0, w_fifo_cnt};
  assign w_accept         = i_es_req_valid & o_es_req_ready;
  assign w_addr_acc       = o_data_sram_req & i_data_sram_addr_ok;
  // Responses are in order, so older cancelled accesses always return first.
  assign w_data_ok_cancel = i_data_sram_data_ok & (r_cancel_cnt != '0);
  assign w_data_ok_live   = i_data_sram_data_ok & (r_cancel_cnt == '0);
  assign w_push           = w_data_ok_live & !i_flush;
  assign w_pop            = o_ms_resp_valid & i_ms_resp_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= DRC_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_es_req_ready = 1'b0;
    case (r_state)
      DRC_IDLE: begin
        o_es_req_ready = !i_reset && !i_flush && !w_fifo_full &&
                         (w_pending < (CNT_W+1)'(RESP_DEPTH));
        if (i_es_req_valid && o_es_req_ready) w_state_nxt = DRC_REQ;
      end
      DRC_REQ: begin
        if (i_data_sram_addr_ok || i_flush) w_state_nxt = DRC_IDLE;
      end
      default: w_state_nxt = DRC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req <= '{wr: i_es_req_wr, size: i_es_req_size, addr: i_es_req_addr,
                 wstrb: i_es_req_wstrb, wdata: i_es_req_wdata};
    end
  end

  // On flush every live access, including one accepted this cycle, becomes cancelled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_live_cnt   <= '0;
      r_cancel_cnt <= '0;
    end else if (i_flush) begin
      r_live_cnt   <= '0;
      r_cancel_cnt <= CNT_W'({1'b0, r_cancel_cnt} + {1'b0, r_live_cnt}
                             + (CNT_W+1)'(w_addr_acc)
                             - (CNT_W+1)'(i_data_sram_data_ok));
    end else begin
      r_live_cnt   <= r_live_cnt + CNT_W'(w_addr_acc) - CNT_W'(w_data_ok_live);
      r_cancel_cnt <= r_cancel_cnt - CNT_W'(w_data_ok_cancel);
    end
  end

  dsram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_data_sram_rdata),
    .o_rdata (o_ms_resp_rdata),
    .o_count (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_data_sram_req   = (r_state == DRC_REQ) & !i_reset;
  assign o_data_sram_wr    = r_req.wr;
  assign o_data_sram_size  = r_req.size;
  assign o_data_sram_addr  = r_req.addr;
  assign o_data_sram_wstrb = r_req.wstrb;
  assign o_data_sram_wdata = r_req.wdata;
  assign o_ms_resp_valid   = !w_fifo_empty & !i_reset;
  assign o_busy            = (r_state == DRC_REQ) | (r_live_cnt != '0) |
                             (r_cancel_cnt != '0);

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Directed bench for dsram_req_ctrl: the bench plays EX, the SRAM port and MEM
// cycle by cycle and compares outputs against hand-computed values.
module tb_dsram_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_req_valid, es_req_wr;
  logic [1:0]  es_req_size;
  logic [31:0] es_req_addr, es_req_wdata;
  logic [3:0]  es_req_wstrb;
  logic        es_req_ready;
  logic        flush;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_resp_valid;
  logic [31:0] ms_resp_rdata;
  logic        ms_resp_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dsram_req_ctrl #(.RESP_DEPTH(2), .CNT_W(2)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_es_req_valid      (es_req_valid),
    .i_es_req_wr         (es_req_wr),
    .i_es_req_size       (es_req_size),
    .i_es_req_addr       (es_req_addr),
    .i_es_req_wstrb      (es_req_wstrb),
    .i_es_req_wdata      (es_req_wdata),
    .o_es_req_ready      (es_req_ready),
    .i_flush             (flush),
    .o_data_sram_req     (data_sram_req),
    .o_data_sram_wr      (data_sram_wr),
    .o_data_sram_size    (data_sram_size),
    .o_data_sram_addr    (data_sram_addr),
    .o_data_sram_wstrb   (data_sram_wstrb),
    .o_data_sram_wdata   (data_sram_wdata),
    .i_data_sram_addr_ok (data_sram_addr_ok),
    .i_data_sram_data_ok (data_sram_data_ok),
    .i_data_sram_rdata   (data_sram_rdata),
    .o_ms_resp_valid     (ms_resp_valid),
    .o_ms_resp_rdata     (ms_resp_rdata),
    .i_ms_resp_ready     (ms_resp_ready),
    .o_busy              (busy)
  );

  // A push into a full FIFO with no pop must never happen.
  always @(negedge clk) begin
    if (reset === 1'b0 && dut.w_push && dut.w_fifo_full && !dut.w_pop) begin
      n_errors++;
      $display("FAIL fifo_overflow: push while full at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [31:0] addr);
    es_req_valid = 1'b1;
    es_req_wr    = 1'b0;
    es_req_size  = 2'd2;
    es_req_addr  = addr;
    es_req_wstrb = 4'h0;
    es_req_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; es_req_valid = 1'b1; es_req_wr = 1'b1;
    es_req_size = 2'd2; es_req_addr = 32'hABCD_0000; es_req_wstrb = 4'hF;
    es_req_wdata = 32'h5555_AAAA; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; ms_resp_ready = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if ({es_req_ready, data_sram_req, ms_resp_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready/req/valid=%b required 000",
               {es_req_ready, data_sram_req, ms_resp_valid});
    end
    step();
    reset = 1'b0; es_req_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, data_sram_addr, data_sram_wdata, data_sram_wstrb, data_sram_wr} !== 70'h0) begin
      n_errors++;
      $display("FAIL reset_fields: got busy=%b addr=%h wdata=%h wstrb=%h wr=%b required all 0",
               busy, data_sram_addr, data_sram_wdata, data_sram_wstrb, data_sram_wr);
    end
    n_checks++;
    if (es_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready_after: got %b required 1", es_req_ready);
    end
  endtask

  task automatic test_single_load();
    set_load(32'h1000_0004);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    #1;
    n_checks++;
    if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr} !== {1'b1, 1'b0, 2'd2, 32'h1000_0004}) begin
      n_errors++;
      $display("FAIL single_req: got req=%b wr=%b size=%0d addr=%h required 1 0 2 10000004",
               data_sram_req, data_sram_wr, data_sram_size, data_sram_addr);
    end
    step();
    data_sram_addr_ok = 1'b0;
    #1;
    n_checks++;
    if ({data_sram_req, busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL single_req_once: got req=%b busy=%b required 0 1", data_sram_req, busy);
    end
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (ms_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_no_bypass: got valid=%b required 0", ms_resp_valid);
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if ({ms_resp_valid, ms_resp_rdata, busy} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      n_errors++;
      $display("FAIL single_resp: got valid=%b rdata=%h busy=%b required 1 deadbeef 0",
               ms_resp_valid, ms_resp_rdata, busy);
    end
    ms_resp_ready = 1'b1;
    step();
    ms_resp_ready = 1'b0;
    #1;
    n_checks++;
    if (ms_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_pop: got valid=%b required 0", ms_resp_valid);
    end
  endtask

  task automatic test_addr_stall();
    es_req_valid = 1'b1; es_req_wr = 1'b1; es_req_size = 2'd2;
    es_req_addr = 32'h2000_0008; es_req_wstrb = 4'hF; es_req_wdata = 32'h1234_5678;
    step();
    es_req_addr = 32'h3000_0000; es_req_wstrb = 4'h1; es_req_wdata = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        data_sram_addr_ok = 1'b1;
        es_req_valid = 1'b0;
      end
      #1;
      n_checks++;
      if ({data_sram_req, data_sram_wr, data_sram_addr, data_sram_wdata, data_sram_wstrb, es_req_ready}
          !== {1'b1, 1'b1, 32'h2000_0008, 32'h1234_5678, 4'hF, 1'b0}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got req=%b wr=%b addr=%h wdata=%h wstrb=%h ready=%b required 1 1 20000008 12345678 f 0",
                 i, data_sram_req, data_sram_wr, data_sram_addr, data_sram_wdata, data_sram_wstrb, es_req_ready);
      end
      step();
    end
    data_sram_addr_ok = 1'b0;
    #1;
    n_checks++;
    if (data_sram_req !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_release: got req=%b required 0", data_sram_req);
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0;
    step();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (ms_resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_store_resp: got valid=%b required 1", ms_resp_valid);
    end
    ms_resp_ready = 1'b1;
    step();
    ms_resp_ready = 1'b0;
    #1;
    n_checks++;
    if ({ms_resp_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL stall_done: got valid=%b busy=%b required 0 0", ms_resp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    ms_resp_ready = 1'b0;
    set_load(32'h0000_0100);
    step();
    data_sram_addr_ok = 1'b1; es_req_addr = 32'h0000_0104;
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11;
    #1;
    n_checks++;
    if (es_req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_second_ready: got %b required 1", es_req_ready);
    end
    step();
    data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b1; es_req_addr = 32'h0000_0108;
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h22;
    #1;
    n_checks++;
    if (es_req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_third_blocked_live: got %b required 0", es_req_ready);
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if ({es_req_ready, dut.w_fifo_cnt, ms_resp_valid, ms_resp_rdata} !== {1'b0, 2'd2, 1'b1, 32'h11}) begin
      n_errors++;
      $display("FAIL bp_full: got ready=%b fifo_cnt=%0d valid=%b rdata=%h required 0 2 1 00000011",
               es_req_ready, dut.w_fifo_cnt, ms_resp_valid, ms_resp_rdata);
    end
    ms_resp_ready = 1'b1;
    step();
    ms_resp_ready = 1'b0;
    #1;
    n_checks++;
    if ({es_req_ready, ms_resp_rdata} !== {1'b1, 32'h22}) begin
      n_errors++;
      $display("FAIL bp_after_pop: got ready=%b rdata=%h required 1 00000022", es_req_ready, ms_resp_rdata);
    end
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    #1;
    n_checks++;
    if ({data_sram_req, data_sram_addr} !== {1'b1, 32'h0000_0108}) begin
      n_errors++;
      $display("FAIL bp_third_req: got req=%b addr=%h required 1 00000108", data_sram_req, data_sram_addr);
    end
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33;
    step();
    data_sram_data_ok = 1'b0; ms_resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'h22}) begin
      n_errors++;
      $display("FAIL bp_order_2: got valid=%b rdata=%h required 1 00000022", ms_resp_valid, ms_resp_rdata);
    end
    step();
    #1;
    n_checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'h33}) begin
      n_errors++;
      $display("FAIL bp_order_3: got valid=%b rdata=%h required 1 00000033", ms_resp_valid, ms_resp_rdata);
    end
    step();
    ms_resp_ready = 1'b0;
    #1;
    n_checks++;
    if ({ms_resp_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL bp_drained: got valid=%b busy=%b required 0 0", ms_resp_valid, busy);
    end
  endtask

  task automatic test_flush_outstanding();
    set_load(32'h0000_0200);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; set_load(32'h0000_0204);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_checks++;
    if ({dut.r_cancel_cnt, dut.r_live_cnt, busy} !== {2'd2, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL flush_cancel2: got cancel=%0d live=%0d busy=%b required 2 0 1",
               dut.r_cancel_cnt, dut.r_live_cnt, busy);
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAA;
    step();
    data_sram_rdata = 32'hBB;
    #1;
    n_checks++;
    if ({ms_resp_valid, dut.r_cancel_cnt} !== {1'b0, 2'd1}) begin
      n_errors++;
      $display("FAIL flush_drop_aa: got valid=%b cancel=%0d required 0 1", ms_resp_valid, dut.r_cancel_cnt);
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if ({ms_resp_valid, dut.r_cancel_cnt, busy} !== {1'b0, 2'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL flush_drop_bb: got valid=%b cancel=%0d busy=%b required 0 0 0",
               ms_resp_valid, dut.r_cancel_cnt, busy);
    end
    set_load(32'h0000_0208);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCC;
    step();
    data_sram_data_ok = 1'b0; ms_resp_ready = 1'b1;
    #1;
    n_checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'hCC}) begin
      n_errors++;
      $display("FAIL flush_new_load: got valid=%b rdata=%h required 1 000000cc", ms_resp_valid, ms_resp_rdata);
    end
    step();
    ms_resp_ready = 1'b0;
  endtask

  task automatic test_flush_coincident();
    set_load(32'h0000_0300);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; set_load(32'h0000_0304);
    step();
    es_req_valid = 1'b0;
    flush = 1'b1; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hEE;
    step();
    flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if ({dut.r_cancel_cnt, dut.r_live_cnt, ms_resp_valid, data_sram_req} !== {2'd1, 2'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL coinc_cancel1: got cancel=%0d live=%0d valid=%b req=%b required 1 0 0 0",
               dut.r_cancel_cnt, dut.r_live_cnt, ms_resp_valid, data_sram_req);
    end
    // New access issued while one cancelled response is still in flight.
    set_load(32'h0000_0310);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hEF;
    step();
    flush = 1'b0; data_sram_rdata = 32'hF0;
    #1;
    n_checks++;
    if ({dut.r_cancel_cnt, dut.r_live_cnt} !== {2'd1, 2'd0}) begin
      n_errors++;
      $display("FAIL coinc_order: got cancel=%0d live=%0d required 1 0", dut.r_cancel_cnt, dut.r_live_cnt);
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if ({dut.r_cancel_cnt, ms_resp_valid, busy} !== {2'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL coinc_drained: got cancel=%0d valid=%b busy=%b required 0 0 0",
               dut.r_cancel_cnt, ms_resp_valid, busy);
    end
    set_load(32'h0000_0308);
    step();
    es_req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_checks++;
    if ({data_sram_req, busy, dut.r_cancel_cnt} !== {1'b0, 1'b0, 2'd0}) begin
      n_errors++;
      $display("FAIL coinc_held_drop: got req=%b busy=%b cancel=%0d required 0 0 0",
               data_sram_req, busy, dut.r_cancel_cnt);
    end
  endtask

  task automatic test_reset_mid();
    set_load(32'h0000_0400);
    step();
    es_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; set_load(32'h0000_0404);
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({data_sram_req, es_req_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_in_cycle: got req=%b ready=%b required 0 0", data_sram_req, es_req_ready);
    end
    step();
    reset = 1'b0; es_req_valid = 1'b0;
    #1;
    n_checks++;
    if ({data_sram_req, ms_resp_valid, busy, dut.r_live_cnt, dut.r_cancel_cnt} !== 7'b0) begin
      n_errors++;
      $display("FAIL rstmid_after: got req=%b valid=%b busy=%b live=%0d cancel=%0d required all 0",
               data_sram_req, ms_resp_valid, busy, dut.r_live_cnt, dut.r_cancel_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_addr_stall();
    test_backpressure();
    test_flush_outstanding();
    test_flush_coincident();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
